seq_unlock_detector: RTL

Parametrised serial unlock-sequence detector for the security path. It compares a stream of SYM_W-bit symbols against a compile-time PATTERN of SEQ_LEN symbols and pulses match on a full correct entry. Failed attempts are counted and trigger timed lockouts. Repeated lockouts escalate to a sticky DEAD state that only RESET clears.

---
 rtl/seq_unlock_detector_if.sv | 39 +++
 rtl/seq_unlock_detector.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/seq_unlock_detector_if.sv
// -----------------------------------------------------------------------------
// seq_unlock_detector_if
// Symbol stream and status bundle for the serial unlock-sequence detector.
//   in_valid  : master -> slave, in_sym carries a symbol this cycle
//   in_sym    : master -> slave, SYM_W-bit symbol
//   clear     : master -> slave, soft abort of the current attempt
//   match     : slave -> master, one-cycle pulse on a correct full entry
//   progress  : slave -> master, symbols matched so far
//   fail_cnt  : slave -> master, failures since last lockout or match
//   locked    : slave -> master, high during a lockout
//   dead      : slave -> master, sticky fail-secure state
// -----------------------------------------------------------------------------
interface seq_unlock_detector_if #(
   parameter int SYM_W    = 1,
   parameter int SEQ_LEN  = 8,
   parameter int MAX_FAIL = 3
);
   localparam int IDX_W  = $clog2(SEQ_LEN);
   localparam int FAIL_W = $clog2(MAX_FAIL + 1);

   logic              in_valid;
   logic [SYM_W-1:0]  in_sym;
   logic              clear;
   logic              match;
   logic [IDX_W-1:0]  progress;
   logic [FAIL_W-1:0] fail_cnt;
   logic              locked;
   logic              dead;

   modport master (
      output in_valid, in_sym, clear,
      input  match, progress, fail_cnt, locked, dead
   );

   modport slave (
      input  in_valid, in_sym, clear,
      output match, progress, fail_cnt, locked, dead
   );
endinterface

// File: rtl/seq_unlock_detector.sv
// -----------------------------------------------------------------------------
// seq_unlock_detector
// Compares a stream of SYM_W-bit symbols against PATTERN (symbol 0 entered
// first) and pulses match on a complete correct entry. Failed attempts are
// counted; MAX_FAIL failures cause a LOCK_CYCLES lockout, and a failure burst
// while lock_cnt == MAX_LOCKS-1 drops into a sticky DEAD state.
//
// Optional feature: define SEQ_TIMEOUT_EN to treat TIMEOUT_CYCLES idle cycles
// in the middle of an entry as a failure.
//
// Ports:
//   clk    : clock, rising edge
//   RESET  : asynchronous active-low reset (also the only exit from DEAD)
//   bus    : seq_unlock_detector_if.slave (in_valid, in_sym, clear in;
//            match, progress, fail_cnt, locked, dead out)
// -----------------------------------------------------------------------------
module seq_unlock_detector #(
   parameter int                         SYM_W          = 1,
   parameter int                         SEQ_LEN        = 8,
   parameter logic [SEQ_LEN*SYM_W-1:0]   PATTERN        = 8'hB4,
   parameter int                         MAX_FAIL       = 3,
   parameter int                         LOCK_CYCLES    = 16,
   parameter int                         MAX_LOCKS      = 2,
   parameter int                         TIMEOUT_CYCLES = 32
) (
   input logic                   clk,
   input logic                   RESET,
   seq_unlock_detector_if.slave  bus
);
   localparam int IDX_W   = $clog2(SEQ_LEN);
   localparam int FAIL_W  = $clog2(MAX_FAIL + 1);
   localparam int LCNT_W  = $clog2(MAX_LOCKS + 1);
   // One timer serves both the lockout and the inter-symbol timeout.
   localparam int TMR_MAX = (LOCK_CYCLES > TIMEOUT_CYCLES) ? LOCK_CYCLES : TIMEOUT_CYCLES;
   localparam int TMR_W   = $clog2(TMR_MAX + 1);

   typedef enum logic [1:0] {
      ST_RUN  = 2'd0,   // IDLE when idx == 0, ACTIVE otherwise
      ST_LOCK = 2'd1,
      ST_DEAD = 2'd2
   } state_t;

   state_t              state_reg, state_next;
   logic [IDX_W-1:0]    idx_reg, idx_next;
   logic [FAIL_W-1:0]   fail_reg, fail_next;
   logic [LCNT_W-1:0]   lcnt_reg, lcnt_next;
   logic [TMR_W-1:0]    timer_reg, timer_next;
   logic                match_reg, match_next;
   logic                failure;

   // Pattern unpacked into one entry per symbol position.
   logic [SYM_W-1:0] pat_sym [SEQ_LEN];
   genvar gi;
   generate
      for (gi = 0; gi < SEQ_LEN; gi++) begin : g_pat
         assign pat_sym[gi] = PATTERN[gi*SYM_W +: SYM_W];
      end
   endgenerate

   // State register
   always_ff @(posedge clk or negedge RESET) begin
      if (!RESET) begin
         state_reg <= ST_RUN;
         idx_reg   <= '0;
         fail_reg  <= '0;
         lcnt_reg  <= '0;
         timer_reg <= '0;
         match_reg <= 1'b0;
      end else begin
         state_reg <= state_next;
         idx_reg   <= idx_next;
         fail_reg  <= fail_next;
         lcnt_reg  <= lcnt_next;
         timer_reg <= timer_next;
         match_reg <= match_next;
      end
   end

   // Next-state logic
   always_comb begin
      state_next = state_reg;
      idx_next   = idx_reg;
      fail_next  = fail_reg;
      lcnt_next  = lcnt_reg;
      timer_next = timer_reg;
      match_next = 1'b0;
      failure    = 1'b0;
      case (state_reg)
         ST_RUN: begin
            timer_next = '0;
            if (bus.clear) begin
               // clear wins over a same-cycle symbol and never counts as a failure
               idx_next = '0;
            end else if (bus.in_valid) begin
               if (bus.in_sym == pat_sym[idx_reg]) begin
                  if (idx_reg == IDX_W'(SEQ_LEN - 1)) begin
                     match_next = 1'b1;
                     idx_next   = '0;
                     fail_next  = '0;
                     lcnt_next  = '0;
                  end else begin
                     idx_next = idx_reg + 1'b1;
                  end
               end else if (idx_reg != '0) begin
                  // The offending symbol may itself be a valid first symbol.
                  failure  = 1'b1;
                  idx_next = (bus.in_sym == pat_sym[0]) ? IDX_W'(1) : '0;
               end
            end
`ifdef SEQ_TIMEOUT_EN
            else if (idx_reg != '0) begin
               if (timer_reg == TMR_W'(TIMEOUT_CYCLES - 1)) begin
                  failure  = 1'b1;
                  idx_next = '0;
               end else begin
                  timer_next = timer_reg + 1'b1;
               end
            end
`endif
            if (failure) begin
               if ((int'(fail_reg) + 1) < MAX_FAIL) begin
                  fail_next = fail_reg + 1'b1;
               end else if (lcnt_reg == LCNT_W'(MAX_LOCKS - 1)) begin
                  state_next = ST_DEAD;
                  idx_next   = '0;
               end else begin
                  state_next = ST_LOCK;
                  lcnt_next  = lcnt_reg + 1'b1;
                  fail_next  = '0;
                  idx_next   = '0;
                  timer_next = '0;
               end
            end
         end
         ST_LOCK: begin
            // Inputs ignored; timer runs 0..LOCK_CYCLES-1.
            if (timer_reg == TMR_W'(LOCK_CYCLES - 1)) begin
               state_next = ST_RUN;
               timer_next = '0;
               idx_next   = '0;
            end else begin
               timer_next = timer_reg + 1'b1;
            end
         end
         ST_DEAD: begin
            // Sticky; only RESET leaves.
         end
         default: begin
            // Unknown encoding: fail secure.
            state_next = ST_DEAD;
            idx_next   = '0;
         end
      endcase
   end

   // Output decode from registered state only
   always_comb begin
      bus.match    = match_reg;
      bus.progress = idx_reg;
      bus.fail_cnt = fail_reg;
      bus.locked   = (state_reg == ST_LOCK);
      // Anything that is neither RUN nor LOCK reports dead.
      bus.dead     = (state_reg != ST_RUN) && (state_reg != ST_LOCK);
   end
endmodule
